// File: rtl/uart_rx_deserializer_if.sv
// Parallel output side of the UART receiver: received word plus its
// one-cycle update strobe and error flags.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  parity_error;
  logic                  framing_error;

  // rx_valid is a strobe with no ready: the consumer must take the word
  // in the single cycle rx_valid is high; data and flags then hold.
  modport master (
    output rx_data,
    output rx_valid,
    output parity_error,
    output framing_error
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input parity_error,
    input framing_error
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start-bit qualification, LSB-first data shift,
// optional parity check and stop-bit check, registered word/flag outputs.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                     UCLK,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic                     rx_en,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     rx_serial,
  output logic                     rx_busy,
  output logic [2:0]               state_dbg_o,
  uart_rx_deserializer_if.master   rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q;
  logic                  rx_meta_q;
  logic                  rx_s_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  par_err_q;
  logic                  par_err_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;

  // Synchronizer idles at 1 so a reset never looks like a start bit.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign shift_d   = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
  assign par_err_d = ((^shift_q) ^ rx_s_q) != par_odd_q;

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!rx_en) begin
        state_q <= IDLE;
      end else if (sample_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s_q) begin
              state_q    <= START;
              tick_cnt_q <= '0;
              par_en_q   <= parity_en;
              par_odd_q  <= parity_odd;
              par_err_q  <= 1'b0;
            end
          end
          START: begin
            if (tick_cnt_q == HALF_M1) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              state_q    <= rx_s_q ? IDLE : DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt_q == LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= shift_d;
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= par_en_q ? PARITY : STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt_q == LAST) begin
              tick_cnt_q <= '0;
              par_err_q  <= par_err_d;
              state_q    <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          STOP: begin
            // Word is delivered even when a flag is set.
            if (tick_cnt_q == LAST) begin
              tick_cnt_q <= '0;
              data_q     <= shift_q;
              perr_q     <= par_en_q & par_err_q;
              ferr_q     <= ~rx_s_q;
              valid_q    <= 1'b1;
              state_q    <= IDLE;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_busy             = (state_q != IDLE);
  assign state_dbg_o         = state_q;
  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.parity_error  = perr_q;
  assign rx_if.framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed and random frames, expected words
// queued at issue time and popped by an independent output monitor.
module tb_uart_rx_deserializer;

  localparam int DW   = 8;
  localparam int OS   = 16;
  localparam int TDIV = 4;
  localparam int EW   = 32 + 2 + DW;

  logic       UCLK        = 1'b0;
  logic       reset       = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx_en       = 1'b0;
  logic       parity_en   = 1'b0;
  logic       parity_odd  = 1'b0;
  logic       rx_serial   = 1'b1;
  logic       rx_busy;
  logic [2:0] state_dbg;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW)) rx_if ();

  uart_rx_deserializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .UCLK        (UCLK),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx_en       (rx_en),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .rx_serial   (rx_serial),
    .rx_busy     (rx_busy),
    .state_dbg_o (state_dbg),
    .rx_if       (rx_if)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 UCLK = ~UCLK;

  int cyc = 0;
  always @(posedge UCLK) cyc <= cyc + 1;

  int tdiv = 0;
  always @(negedge UCLK) begin
    tdiv        = (tdiv + 1) % TDIV;
    sample_tick = (tdiv == 0);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Packed entry: {expected valid cycle, framing_error, parity_error, data}
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] last_data;
  logic          last_perr;
  logic          last_ferr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [EW-1:0] e;
  always @(negedge UCLK) begin
    if (!reset) begin
      last_data = '0;
      last_perr = 1'b0;
      last_ferr = 1'b0;
    end else if (rx_if.rx_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got rx_valid data 0x%0h expected no frame", rx_if.rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data",       64'(rx_if.rx_data),       64'(e[DW-1:0]));
        check("parity_error",  64'(rx_if.parity_error),  64'(e[DW]));
        check("framing_error", 64'(rx_if.framing_error), 64'(e[DW+1]));
        check("valid_cycle",   64'(cyc),                 64'(e[EW-1:DW+2]));
        check("busy_at_valid", 64'(rx_busy),             64'd0);
        last_data = e[DW-1:0];
        last_perr = e[DW];
        last_ferr = e[DW+1];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the falling edge just after a sample tick.
  task automatic wait_tick();
    do @(posedge UCLK); while (!sample_tick);
    @(negedge UCLK);
  endtask

  // abort_kind: 0 none, 1 drop rx_en, 2 assert reset; applied mid-bit abort_bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic stop, input int abort_bit,
                            input int abort_kind, input int idle_ticks);
    logic        bits[$];
    int          ticks;
    logic [31:0] vcyc;
    logic        perr;
    parity_en  = pen;
    parity_odd = podd;
    bits.push_back(1'b0);
    for (int k = 0; k < DW; k++) bits.push_back(d[k]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stop);
    if (abort_kind == 0) begin
      // Detection lands on the tick after the line falls; stop is sampled
      // half a bit into the start plus one bit per data/parity/stop bit.
      ticks = OS / 2 + DW * OS + (pen ? OS : 0) + OS;
      vcyc  = 32'(cyc + TDIV * (ticks + 1));
      perr  = pen & (((^d) ^ pbit) != podd);
      exp_q.push_back({vcyc, ~stop, perr, d});
    end
    for (int i = 0; i < bits.size(); i++) begin
      rx_serial = bits[i];
      for (int t = 0; t < OS; t++) begin
        if (i == abort_bit && t == OS / 2) begin
          if (abort_kind == 1) begin
            rx_en = 1'b0;
            @(negedge UCLK);
            check("en_drop_busy",  64'(rx_busy),             64'd0);
            check("en_drop_valid", 64'(rx_if.rx_valid),      64'd0);
            check("en_drop_data",  64'(rx_if.rx_data),       64'(last_data));
            check("en_drop_perr",  64'(rx_if.parity_error),  64'(last_perr));
            check("en_drop_ferr",  64'(rx_if.framing_error), 64'(last_ferr));
            rx_serial = 1'b1;
            repeat (2 * OS) wait_tick();
            rx_en = 1'b1;
            wait_tick();
          end else begin
            reset = 1'b0;
            #1;
            check("rst_data",  64'(rx_if.rx_data),       64'd0);
            check("rst_valid", 64'(rx_if.rx_valid),      64'd0);
            check("rst_perr",  64'(rx_if.parity_error),  64'd0);
            check("rst_ferr",  64'(rx_if.framing_error), 64'd0);
            check("rst_busy",  64'(rx_busy),             64'd0);
            rx_serial = 1'b1;
            repeat (3) @(negedge UCLK);
            reset = 1'b1;
            repeat (2) wait_tick();
          end
          return;
        end
        wait_tick();
      end
    end
    rx_serial = 1'b1;
    repeat (idle_ticks) wait_tick();
  endtask

  // ---------------- main sequence ----------------
  logic [DW-1:0] rd;
  logic          rpen, rpodd, rpbit, rstop;

  initial begin
    repeat (4) @(negedge UCLK);
    check("reset_data",  64'(rx_if.rx_data),       64'd0);
    check("reset_valid", 64'(rx_if.rx_valid),      64'd0);
    check("reset_perr",  64'(rx_if.parity_error),  64'd0);
    check("reset_ferr",  64'(rx_if.framing_error), 64'd0);
    check("reset_busy",  64'(rx_busy),             64'd0);
    reset = 1'b1;
    rx_en = 1'b1;
    repeat (2) wait_tick();
    check("idle_busy", 64'(rx_busy), 64'd0);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, 0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 2 * OS);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);

    // Glitch: low for three ticks only, must be rejected at the start sample.
    rx_serial = 1'b0;
    wait_tick();
    check("glitch_busy_high", 64'(rx_busy), 64'd1);
    repeat (2) wait_tick();
    rx_serial = 1'b1;
    repeat (OS) wait_tick();
    check("glitch_busy_low", 64'(rx_busy), 64'd0);

    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);

    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 5, 2, 0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);
    send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);

    for (int n = 0; n < 12; n++) begin
      rd    = DW'($urandom);
      rpen  = 1'($urandom_range(0, 1));
      rpodd = 1'($urandom_range(0, 1));
      rpbit = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(rd, rpen, rpodd, rpbit, rstop, -1, 0,
                 rstop ? int'($urandom_range(0, 3)) : 2 * OS);
    end

    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(negedge UCLK);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
